// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline observations in, stall/flush strobes,
// halt status and event counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned LD_W  = 3;

    // Decode-control stage view
    logic [REG_W-1:0] idc_rs1;
    logic [REG_W-1:0] idc_rs2;
    logic             idc_rs1_used;
    logic             idc_rs2_used;
    logic             idc_is_debug;

    // EX stage view
    logic [REG_W-1:0] ex_rd;
    logic             ex_rf_wr_en;
    logic [LD_W-1:0]  ex_dm_rd_ctrl;
    logic             ex_redirect;

    // Memory handshakes and debug control
    logic             mem_req;
    logic             mem_ready;
    logic             imem_ready;
    logic             dbg_resume;

    // Controller outputs
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             flush_ex;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: drives observations, consumes strobes
    modport master (
        output idc_rs1, idc_rs2, idc_rs1_used, idc_rs2_used, idc_is_debug,
        output ex_rd, ex_rf_wr_en, ex_dm_rd_ctrl, ex_redirect,
        output mem_req, mem_ready, imem_ready, dbg_resume,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
        input  halted, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  idc_rs1, idc_rs2, idc_rs1_used, idc_rs2_used, idc_is_debug,
        input  ex_rd, ex_rf_wr_en, ex_dm_rd_ctrl, ex_redirect,
        input  mem_req, mem_ready, imem_ready, dbg_resume,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
        output halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves memory waits,
// redirects, load-use hazards and fetch misses, runs the debug-halt FSM and keeps
// saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             mw;
    logic             lu;
    logic             any_stall;
    logic             redirect_fire;

    logic             stall_if_c;
    logic             stall_id_c;
    logic             stall_ex_c;
    logic             stall_mem_c;
    logic             flush_id_c;
    logic             flush_ex_c;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Hazard terms: MEM wait and load-use dependency between EX and decode-control
    assign mw = hz.mem_req & ~hz.mem_ready;
    assign lu = (hz.ex_dm_rd_ctrl != '0) & hz.ex_rf_wr_en & (hz.ex_rd != '0) &
                ((hz.idc_rs1_used & (hz.idc_rs1 == hz.ex_rd)) |
                 (hz.idc_rs2_used & (hz.idc_rs2 == hz.ex_rd)));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall/flush decode; MEM wait outranks everything in both states
    always_comb begin
        state_d       = state_q;
        stall_if_c    = 1'b0;
        stall_id_c    = 1'b0;
        stall_ex_c    = 1'b0;
        stall_mem_c   = 1'b0;
        flush_id_c    = 1'b0;
        flush_ex_c    = 1'b0;
        redirect_fire = 1'b0;

        if (!reset) begin
            // Keep bubbles flowing into ID/EX while the pipeline is held in reset
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mw) begin
                        stall_if_c  = 1'b1;
                        stall_id_c  = 1'b1;
                        stall_ex_c  = 1'b1;
                        stall_mem_c = 1'b1;
                    end else if (hz.ex_redirect) begin
                        // Wrong-path instructions in IF/ID are discarded, so a
                        // pending load-use on them is moot
                        flush_id_c    = 1'b1;
                        flush_ex_c    = 1'b1;
                        redirect_fire = 1'b1;
                    end else if (lu) begin
                        stall_if_c = 1'b1;
                        stall_id_c = 1'b1;
                        flush_ex_c = 1'b1;
                    end else if (hz.idc_is_debug) begin
                        stall_if_c = 1'b1;
                        stall_id_c = 1'b1;
                        flush_ex_c = 1'b1;
                        state_d    = ST_HALT;
                    end else if (!hz.imem_ready) begin
                        stall_if_c = 1'b1;
                        flush_id_c = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (mw) begin
                        stall_if_c  = 1'b1;
                        stall_id_c  = 1'b1;
                        stall_ex_c  = 1'b1;
                        stall_mem_c = 1'b1;
                    end else if (!hz.dbg_resume) begin
                        // Hold the debug instruction in decode-control while older
                        // instructions drain through MEM/WB
                        stall_if_c = 1'b1;
                        stall_id_c = 1'b1;
                        flush_ex_c = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    assign any_stall = stall_if_c | stall_id_c | stall_ex_c | stall_mem_c;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (any_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_fire && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_if  = stall_if_c;
    assign hz.stall_id  = stall_id_c;
    assign hz.stall_ex  = stall_ex_c;
    assign hz.stall_mem = stall_mem_c;
    assign hz.flush_id  = flush_id_c;
    assign hz.flush_ex  = flush_ex_c;
    assign hz.halted    = (state_q == ST_HALT);
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle-per-row vector table
// checked through a scoreboard queue, plus a counter-saturation sequence on a
// narrow-counter instance.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic reset4;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  hz4 ();

    pipeline_hazard_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .hz    (hz4)
    );

    // mode: 0 = no load in EX (rs2 matches), 1 = load, rs2 dependency,
    //       2 = load, rs1 dependency, 3 = load, matching rs2 marked unused
    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic [4:0] exrd;
        logic       redir;
        logic       mreq;
        logic       mrdy;
        logic       irdy;
        logic       dbg;
        logic       resume;
        logic       exp_h;
        logic [5:0] exp_o;   // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex}
        logic       finc;    // row is an accepted redirect
    } vec_t;

    typedef struct {
        int          idx;
        logic [5:0]  o;
        logic        h;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    vec_t        tbl[$];
    string       tnm[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_sc;
    logic [31:0] m_fc;

    task automatic add(input string nm, input logic rst, input logic [1:0] mode,
                       input logic [4:0] exrd, input logic redir, input logic mreq,
                       input logic mrdy, input logic irdy, input logic dbg,
                       input logic resume, input logic h, input logic [5:0] o,
                       input logic finc);
        vec_t v;
        v.rst = rst; v.mode = mode; v.exrd = exrd; v.redir = redir;
        v.mreq = mreq; v.mrdy = mrdy; v.irdy = irdy; v.dbg = dbg;
        v.resume = resume; v.exp_h = h; v.exp_o = o; v.finc = finc;
        tbl.push_back(v);
        tnm.push_back(nm);
    endtask

    task automatic drive(input vec_t v);
        reset               = v.rst;
        hz.ex_dm_rd_ctrl    = (v.mode == 2'd0) ? 3'b000 : 3'b011;
        hz.ex_rf_wr_en      = 1'b1;
        hz.ex_rd            = v.exrd;
        hz.idc_rs1          = (v.mode == 2'd2) ? 5'd5 : 5'd7;
        hz.idc_rs1_used     = 1'b1;
        hz.idc_rs2          = (v.mode == 2'd2) ? 5'd9 : 5'd5;
        hz.idc_rs2_used     = (v.mode == 2'd0) || (v.mode == 2'd1);
        hz.idc_is_debug     = v.dbg;
        hz.ex_redirect      = v.redir;
        hz.mem_req          = v.mreq;
        hz.mem_ready        = v.mrdy;
        hz.imem_ready       = v.irdy;
        hz.dbg_resume       = v.resume;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue want one entry");
        end else begin
            e = sb.pop_front();
            chk({tnm[e.idx], "/outs"},
                32'({hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                     hz.flush_id, hz.flush_ex}), 32'(e.o));
            chk({tnm[e.idx], "/halted"}, 32'(hz.halted), 32'(e.h));
            chk({tnm[e.idx], "/stall_cnt"}, hz.stall_cnt, e.sc);
            chk({tnm[e.idx], "/flush_cnt"}, hz.flush_cnt, e.fc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        //   name          rst md exrd rd mq mr ir dbg res h  outs       finc
        add("rst",         0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 6'b000011, 0);
        add("idle",        1, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 0);
        add("lu_rs2",      1, 1, 5'd5, 0, 0, 0, 1, 0, 0, 0, 6'b110001, 0);
        add("lu_next",     1, 0, 5'd5, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 0);
        add("lu_rd0",      1, 1, 5'd0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 0);
        add("lu_rs1",      1, 2, 5'd5, 0, 0, 0, 1, 0, 0, 0, 6'b110001, 0);
        add("lu_unused",   1, 3, 5'd5, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 0);
        add("redir_lu",    1, 1, 5'd5, 1, 0, 0, 1, 0, 0, 0, 6'b000011, 1);
        add("imiss",       1, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 6'b100010, 0);
        add("mw_redir1",   1, 0, 5'd0, 1, 1, 0, 1, 0, 0, 0, 6'b111100, 0);
        add("mw_redir2",   1, 0, 5'd0, 1, 1, 0, 1, 0, 0, 0, 6'b111100, 0);
        add("mw_redir3",   1, 0, 5'd0, 1, 1, 0, 1, 0, 0, 0, 6'b111100, 0);
        add("mw_done",     1, 0, 5'd0, 1, 1, 1, 1, 0, 0, 0, 6'b000011, 1);
        add("mw_lu_dbg",   1, 1, 5'd5, 0, 1, 0, 1, 1, 0, 0, 6'b111100, 0);
        add("dbg",         1, 0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 6'b110001, 0);
        add("halt1",       1, 0, 5'd0, 0, 0, 0, 1, 1, 0, 1, 6'b110001, 0);
        add("halt2",       1, 0, 5'd0, 0, 0, 0, 0, 1, 0, 1, 6'b110001, 0);
        add("halt3",       1, 1, 5'd5, 0, 0, 0, 1, 1, 0, 1, 6'b110001, 0);
        add("halt4",       1, 0, 5'd0, 0, 0, 0, 1, 1, 0, 1, 6'b110001, 0);
        add("halt5",       1, 0, 5'd0, 0, 0, 0, 1, 1, 0, 1, 6'b110001, 0);
        add("halt_mw_res", 1, 0, 5'd0, 0, 1, 0, 1, 1, 1, 1, 6'b111100, 0);
        add("resume",      1, 0, 5'd0, 0, 0, 0, 1, 1, 1, 1, 6'b000000, 0);
        add("after_res",   1, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 0);
        add("dbg_b",       1, 0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 6'b110001, 0);
        add("hb1",         1, 0, 5'd0, 0, 0, 0, 1, 1, 0, 1, 6'b110001, 0);
        add("hb2",         1, 0, 5'd0, 0, 0, 0, 1, 1, 0, 1, 6'b110001, 0);
        add("rst_halt",    0, 0, 5'd0, 0, 1, 0, 1, 1, 0, 1, 6'b000011, 0);
        add("post_rst",    1, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 0);
        add("lu_again",    1, 1, 5'd5, 0, 0, 0, 1, 0, 0, 0, 6'b110001, 0);
        add("final",       1, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 6'b000000, 0);

        // Narrow instance idles in reset until its own sequence
        reset4            = 1'b0;
        hz4.idc_rs1       = 5'd0;
        hz4.idc_rs2       = 5'd0;
        hz4.idc_rs1_used  = 1'b0;
        hz4.idc_rs2_used  = 1'b0;
        hz4.idc_is_debug  = 1'b0;
        hz4.ex_rd         = 5'd0;
        hz4.ex_rf_wr_en   = 1'b0;
        hz4.ex_dm_rd_ctrl = 3'b000;
        hz4.ex_redirect   = 1'b0;
        hz4.mem_req       = 1'b0;
        hz4.mem_ready     = 1'b0;
        hz4.imem_ready    = 1'b1;
        hz4.dbg_resume    = 1'b0;

        idle = tbl[0];
        drive(idle);
        repeat (2) @(posedge clk);
        m_sc = 32'd0;
        m_fc = 32'd0;

        // Table: one row per cycle, expectations queued at drive time
        for (int i = 0; i < tbl.size(); i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            drive(tbl[i]);
            e.idx = i; e.o = tbl[i].exp_o; e.h = tbl[i].exp_h; e.sc = m_sc; e.fc = m_fc;
            sb.push_back(e);
            @(negedge clk);
            check_pop();
            if (!tbl[i].rst) begin
                m_sc = 32'd0;
                m_fc = 32'd0;
            end else begin
                if (|tbl[i].exp_o[5:2]) m_sc = m_sc + 32'd1;
                if (tbl[i].finc)        m_fc = m_fc + 32'd1;
            end
        end

        // Saturation: 20 memory-wait cycles, then 20 redirects, on 4-bit counters
        @(posedge clk);
        #1;
        reset4        = 1'b1;
        hz4.mem_req   = 1'b1;
        hz4.mem_ready = 1'b0;
        hz4.ex_redirect = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("sat_stall_cnt", 32'(hz4.stall_cnt), (i > 15) ? 32'd15 : 32'(i));
            chk("sat_flush_hold", 32'(hz4.flush_cnt), 32'd0);
        end
        @(posedge clk);
        #1;
        hz4.mem_req = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("sat_stall_top", 32'(hz4.stall_cnt), 32'd15);
            chk("sat_flush_cnt", 32'(hz4.flush_cnt), (j > 15) ? 32'd15 : 32'(j));
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RV64 pipeline. It watches the decoded instruction leaving the decode-control stage, the instruction in EX, and the data/instruction memory handshakes. Each cycle it produces per-stage `stall`/`flush` strobes that sequence the IF, ID, EX and MEM pipeline registers. It also runs a debug-halt state machine and keeps saturating stall and flush event counters.

## Interface
Parameters:
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `idc_rs1`, `idc_rs2`  in  5 each  source registers of the instruction held in the decode-control output register.
- `idc_rs1_used`, `idc_rs2_used`  in  1 each  the corresponding source is actually read.
- `idc_is_debug`  in  1  the decode-control instruction is a debug/ebreak instruction.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_rf_wr_en`  in  1  EX instruction writes the register file.
- `ex_dm_rd_ctrl`  in  3  EX data-memory read control; nonzero means a load.
- `ex_redirect`  in  1  EX resolved a taken branch or jump this cycle.
- `mem_req`  in  1  MEM stage has a data access in flight.
- `mem_ready`  in  1  data memory completes the MEM access this cycle.
- `imem_ready`  in  1  instruction fetch data valid this cycle.
- `dbg_resume`  in  1  debugger releases a halt.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`  out  1 each  hold the corresponding pipeline register.
- `flush_id`, `flush_ex`  out  1 each  clear the decode / decode-control register (insert a bubble).
- `halted`  out  1  FSM is in HALT.
- `stall_cnt`  out  `CNT_W`  cycles with any stall asserted.
- `flush_cnt`  out  `CNT_W`  accepted redirects.

## Operation
FSM states: RUN and HALT. The state is registered; all stall/flush outputs are combinational from the state and the current inputs.

Derived terms:
- `mw` = `mem_req` & ~`mem_ready`.
- `lu` = (`ex_dm_rd_ctrl` != 0) & `ex_rf_wr_en` & (`ex_rd` != 0) & ((`idc_rs1_used` & `idc_rs1` == `ex_rd`) | (`idc_rs2_used` & `idc_rs2` == `ex_rd`)).

RUN priority, first match wins; unlisted outputs are 0:
1. `mw`: all four stalls = 1. No flush. Redirect, load-use and debug are all ignored this cycle.
2. `ex_redirect`: `flush_id` = `flush_ex` = 1, no stalls. A redirect overrides load-use.
3. `lu`: `stall_if` = `stall_id` = 1 and `flush_ex` = 1, inserting one bubble into EX.
4. `idc_is_debug`: `stall_if` = `stall_id` = 1 and `flush_ex` = 1. Next state is HALT.
5. ~`imem_ready`: `stall_if` = 1, `flush_id` = 1.

HALT:
- `mw`: all four stalls = 1.
- Otherwise, if `dbg_resume` = 0: `stall_if` = `stall_id` = 1, `flush_ex` = 1. Older instructions drain through MEM/WB.
- Otherwise (`dbg_resume` = 1): all outputs 0. The debug instruction enters EX and the next state is RUN.
- `dbg_resume` is ignored while `mw`.
- `halted` = 1 throughout HALT.

Counters:
- `stall_cnt` increments on every clock edge on which any `stall_*` was 1.
- `flush_cnt` increments when RUN rule 2 fired.
- Both saturate at all-ones and do not wrap.

Downstream stage registers give flush precedence over stall; this block may assert both on one stage.

## Timing
Reset, while `reset` = 0 at an edge:
- state becomes RUN;
- `stall_cnt` and `flush_cnt` become 0;
- `halted` = 0 from the following cycle.

Combinational outputs while `reset` is low:
- `flush_id` = `flush_ex` = 1;
- all stalls 0.

Other timing rules:
- Stall/flush latency: 0 cycles from the inputs. State, `halted` and counters update 1 cycle later.
- A load-use hazard costs exactly 1 bubble. In the next cycle the load is in MEM, so `lu` is false and forwarding covers the dependency.
- Debug detection to `halted` = 1: 1 cycle. `dbg_resume` to `halted` = 0: 1 cycle. The resume cycle itself has no stall.
- Reset taken during HALT returns to RUN immediately, and no resume is needed.

## Test plan
- Load-use: `ex_dm_rd_ctrl` = 3'b011, `ex_rd` = 5, `ex_rf_wr_en` = 1, `idc_rs2` = 5, `idc_rs2_used` = 1 -> for exactly one cycle `stall_if` = `stall_id` = `flush_ex` = 1; `stall_cnt` becomes +1. With `ex_rd` = 0 -> no stall.
- Redirect plus load-use in the same cycle -> `flush_id` = `flush_ex` = 1, all stalls 0, `flush_cnt` becomes +1.
- `mem_req` = 1, `mem_ready` = 0 for 3 cycles while `ex_redirect` = 1 -> all four stalls = 1 for 3 cycles, no flush, `flush_cnt` unchanged, `stall_cnt` becomes +3. The redirect then applies in the cycle `mem_ready` = 1.
- `idc_is_debug` = 1 -> `halted` = 1 on the next cycle. Stalls hold for 5 cycles. Then `dbg_resume` = 1 -> outputs 0 in that cycle, `halted` = 0 on the next cycle.
- Reset asserted on the 3rd HALT cycle -> `halted` = 0 and both counters = 0 after the edge. `flush_id` = `flush_ex` = 1 while `reset` is low.
- With `CNT_W` = 4, hold a stall for 20 cycles -> `stall_cnt` stops at 4'hF.
